cp0_unit: RTL

Parametrised coprocessor-0 register block for the MIPS core, replacing the fixed-layout CP0 file. It holds the architectural CP0 state and applies exception/ERET side effects. It adds Wired-bounded Random for TLBWR, IM/IE-masked interrupt-pending generation, a sticky timer interrupt in Cause.IP7, and a TLB-sized Index field. It sits beside the MEM stage: MTC0 writes and exception commits arrive from MEM, and MFC0 reads are served combinationally to EX/MEM.

---
 rtl/cp0_unit.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 register block for the MIPS core.
//
// Holds the architectural CP0 state, applies MTC0 writes through per-register
// write masks, and applies exception/ERET side effects committed from MEM.
// Reads (MFC0) are combinational from the current register state.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   we_i/waddr_i/data_i      MTC0 write strobe, register number, write data
//   raddr_i/data_o           MFC0 register number and read data (no bypass)
//   int_i                    level-sensitive hardware interrupt lines
//   excepttype_i             committed exception code (0 = none, 0x0e = ERET)
//   current_inst_addr_i      PC of the excepting instruction
//   is_in_delay_slot_i       excepting instruction sits in a delay slot
//   bad_address_i            faulting address for AdEL/AdES
//   *_o                      register values, interrupt pending, timer match
//
// Build option: CP0_COUNT_HALF_EN makes Count advance every other cycle.
module cp0_unit #(
  parameter int          TLB_ENTRIES = 16,
  parameter int          HW_INT      = 6,
  parameter logic [31:0] EBASE_RESET = 32'h80000000,
  localparam int         IW          = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [31:0]       data_i,
  input  logic [4:0]        raddr_i,
  output logic [31:0]       data_o,
  input  logic [HW_INT-1:0] int_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       current_inst_addr_i,
  input  logic              is_in_delay_slot_i,
  input  logic [31:0]       bad_address_i,
  output logic [31:0]       status_o,
  output logic [31:0]       cause_o,
  output logic [31:0]       epc_o,
  output logic [31:0]       ebase_o,
  output logic [31:0]       entryhi_o,
  output logic [31:0]       badvaddr_o,
  output logic [31:0]       count_o,
  output logic [31:0]       compare_o,
  output logic [31:0]       index_o,
  output logic [IW-1:0]     random_o,
  output logic              int_pending_o,
  output logic              timer_int_o
);

  localparam logic [IW-1:0] RAND_MAX    = IW'(TLB_ENTRIES - 1);
  localparam logic [31:0]   INDEX_MASK  = 32'h80000000 | ((32'd1 << IW) - 32'd1);
  localparam logic [31:0]   ELO_MASK    = 32'h03ffffff;
  localparam logic [31:0]   PM_MASK     = 32'h1fffe000;
  localparam logic [31:0]   EHI_MASK    = 32'hffffe0ff;
  localparam logic [31:0]   CAUSE_MASK  = 32'h00c00300;
  localparam logic [31:0]   EBASE_MASK  = 32'h3ffff000;

  localparam logic [31:0] STATUS_RESET = 32'h10000000;
  localparam logic [31:0] CONFIG_RESET = 32'h00008000;

  logic [31:0]   index_q, index_d;
  logic [IW-1:0] random_q, random_d;
  logic [31:0]   entrylo0_q, entrylo0_d;
  logic [31:0]   entrylo1_q, entrylo1_d;
  logic [31:0]   pagemask_q, pagemask_d;
  logic [IW-1:0] wired_q, wired_d;
  logic [31:0]   badvaddr_q, badvaddr_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   entryhi_q, entryhi_d;
  logic [31:0]   compare_q, compare_d;
  logic [31:0]   status_q, status_d;
  logic [31:0]   cause_q, cause_d;
  logic [31:0]   epc_q, epc_d;
  logic [31:0]   ebase_q, ebase_d;
  logic [31:0]   config_q, config_d;
  logic          timer_int_q, timer_int_d;
  logic          int_pending_q, int_pending_d;

  logic       wr_wired, wr_count, wr_compare;
  logic       count_inc;
  logic       exc_hit, exc_addr, eret;
  logic [4:0] exc_code;
  logic [5:0] hw_ext;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign wr_wired   = we_i && (waddr_i == 5'd6);
  assign wr_count   = we_i && (waddr_i == 5'd9);
  assign wr_compare = we_i && (waddr_i == 5'd11);

`ifdef CP0_COUNT_HALF_EN
  logic tog_q, tog_d;

  always_comb begin
    tog_d = ~tog_q;
    if (wr_count) tog_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tog_q <= 1'b0;
    else      tog_q <= tog_d;
  end

  assign count_inc = tog_q;
`else
  assign count_inc = 1'b1;
`endif

  always_comb begin
    exc_hit  = 1'b1;
    exc_addr = 1'b0;
    exc_code = 5'd0;
    case (excepttype_i)
      32'h01:  exc_code = 5'd0;
      32'h08:  exc_code = 5'd8;
      32'h0a:  exc_code = 5'd10;
      32'h0c:  exc_code = 5'd12;
      32'h0d:  exc_code = 5'd13;
      32'h0f:  begin exc_code = 5'd4; exc_addr = 1'b1; end
      32'h0b:  begin exc_code = 5'd5; exc_addr = 1'b1; end
      default: exc_hit = 1'b0;
    endcase
  end

  assign eret = (excepttype_i == 32'h0e);

  // Interrupt lines zero-extended to six; IP7 is shared with the timer.
  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT-1:0] = int_i;
  end

  always_comb begin
    index_d    = index_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    pagemask_d = pagemask_q;
    wired_d    = wired_q;
    badvaddr_d = badvaddr_q;
    entryhi_d  = entryhi_q;
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    ebase_d    = ebase_q;
    config_d   = config_q;
    count_d    = count_q + {31'd0, count_inc};

    if (we_i) begin
      case (waddr_i)
        5'd0:  index_d    = merge(index_q, data_i, INDEX_MASK);
        5'd2:  entrylo0_d = data_i & ELO_MASK;
        5'd3:  entrylo1_d = data_i & ELO_MASK;
        5'd5:  pagemask_d = data_i & PM_MASK;
        5'd6:  wired_d    = data_i[IW-1:0];
        5'd9:  count_d    = data_i;
        5'd10: entryhi_d  = data_i & EHI_MASK;
        5'd11: compare_d  = data_i;
        5'd12: status_d   = data_i;
        5'd13: cause_d    = merge(cause_q, data_i, CAUSE_MASK);
        5'd14: epc_d      = data_i;
        5'd15: ebase_d    = merge(ebase_q, data_i, EBASE_MASK);
        5'd16: config_d   = data_i;
        default: ;
      endcase
    end

    // Random stays within [Wired, TLB_ENTRIES-1]; a Wired at the top pins it.
    if (wr_wired || wired_q == RAND_MAX || random_q == wired_q)
      random_d = RAND_MAX;
    else
      random_d = random_q - 1'b1;

    // Compare write clears the match even if it coincides with one.
    timer_int_d = timer_int_q;
    if (count_q == compare_q) timer_int_d = 1'b1;
    if (wr_compare)           timer_int_d = 1'b0;

    cause_d[15:10] = hw_ext | {timer_int_q, 5'd0};

    // Exception/ERET fields are applied last so they override MTC0 on
    // the bits they touch.
    if (exc_hit) begin
      if (!status_q[1]) begin
        epc_d       = is_in_delay_slot_i ? current_inst_addr_i - 32'd4
                                         : current_inst_addr_i;
        cause_d[31] = is_in_delay_slot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
      if (exc_addr) badvaddr_d = bad_address_i;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end

    int_pending_d = status_q[0] & ~status_q[1] & ~status_q[2] &
                    (|(status_q[15:8] & cause_q[15:8]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q       <= '0;
      random_q      <= RAND_MAX;
      entrylo0_q    <= '0;
      entrylo1_q    <= '0;
      pagemask_q    <= '0;
      wired_q       <= '0;
      badvaddr_q    <= '0;
      count_q       <= '0;
      entryhi_q     <= '0;
      compare_q     <= '0;
      status_q      <= STATUS_RESET;
      cause_q       <= '0;
      epc_q         <= '0;
      ebase_q       <= EBASE_RESET;
      config_q      <= CONFIG_RESET;
      timer_int_q   <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      index_q       <= index_d;
      random_q      <= random_d;
      entrylo0_q    <= entrylo0_d;
      entrylo1_q    <= entrylo1_d;
      pagemask_q    <= pagemask_d;
      wired_q       <= wired_d;
      badvaddr_q    <= badvaddr_d;
      count_q       <= count_d;
      entryhi_q     <= entryhi_d;
      compare_q     <= compare_d;
      status_q      <= status_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      ebase_q       <= ebase_d;
      config_q      <= config_d;
      timer_int_q   <= timer_int_d;
      int_pending_q <= int_pending_d;
    end
  end

  always_comb begin
    data_o = '0;
    case (raddr_i)
      5'd0:  data_o = index_q;
      5'd1:  data_o = 32'(random_q);
      5'd2:  data_o = entrylo0_q;
      5'd3:  data_o = entrylo1_q;
      5'd5:  data_o = pagemask_q;
      5'd6:  data_o = 32'(wired_q);
      5'd8:  data_o = badvaddr_q;
      5'd9:  data_o = count_q;
      5'd10: data_o = entryhi_q;
      5'd11: data_o = compare_q;
      5'd12: data_o = status_q;
      5'd13: data_o = cause_q;
      5'd14: data_o = epc_q;
      5'd15: data_o = ebase_q;
      5'd16: data_o = config_q;
      default: data_o = '0;
    endcase
  end

  assign status_o      = status_q;
  assign cause_o       = cause_q;
  assign epc_o         = epc_q;
  assign ebase_o       = ebase_q;
  assign entryhi_o     = entryhi_q;
  assign badvaddr_o    = badvaddr_q;
  assign count_o       = count_q;
  assign compare_o     = compare_q;
  assign index_o       = index_q;
  assign random_o      = random_q;
  assign int_pending_o = int_pending_q;
  assign timer_int_o   = timer_int_q;

endmodule
